// File: rtl/vram_note_pkg.sv
// Shared types and constants for the note-display VRAM writer.
//   COLS, ROWS, VRAM_WORDS : screen geometry (two 16-bit cells per 32-bit word)
//   symbol_t               : packed 16-bit note symbol
//   cmd_t                  : one note-placement command
//   state_e                : write-master FSM states
//   cell_index()           : linear cell index row*cols+col (13 bits)
package vram_note_pkg;

  localparam int COLS       = 80;
  localparam int ROWS       = 60;
  localparam int VRAM_WORDS = ROWS * COLS / 2;

  typedef struct packed {
    logic [4:0] glyph;
    logic [2:0] rsvd_hi;
    logic [1:0] ledger;
    logic       rsvd_mid;
    logic [1:0] line;
    logic       rsvd_lo;
    logic [1:0] dot;
  } symbol_t;

  typedef enum logic {
    OP_PUT   = 1'b0,
    OP_CLEAR = 1'b1
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [5:0] row;
    logic [6:0] col;
    symbol_t    symbol;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUT,
    ST_CLEAR
  } state_e;

  function automatic logic [12:0] cell_index(input logic [5:0] row,
                                             input logic [6:0] col,
                                             input int         cols);
    return 13'(row) * 13'(cols) + 13'(col);
  endfunction

endpackage

// File: rtl/note_cmd_fifo.sv
// Synchronous first-word-fall-through command FIFO.
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push/push_data : write side; a push while full is ignored
//   pop/head   : read side; head is valid whenever empty is low
//   full/empty : occupancy flags
// DEPTH must be a power of two, at least 2.
module note_cmd_fifo
  import vram_note_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vram_note_writer.sv
// Avalon-MM write master filling the note-display VRAM from (row, col, symbol)
// commands. Two 16-bit cells per 32-bit word: even cell in the low half.
//   clk, rst          : clock, asynchronous active-high reset
//   cmd_*             : upstream valid/ready command port (op 0=PUT, 1=CLEAR)
//   avm_*             : Avalon-MM write master toward the VRAM slave
//   busy              : FIFO non-empty or a write/clear in flight
//   err               : one-cycle pulse when a command is dropped
// Build option: define VRAM_NOTE_WRITER_CLEAR_EN to implement CLEAR; without it
// CLEAR commands are dropped and flagged on err like out-of-range PUTs.
module vram_note_writer
  import vram_note_pkg::*;
#(
  parameter int COLS       = vram_note_pkg::COLS,
  parameter int ROWS       = vram_note_pkg::ROWS,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [5:0]        cmd_row,
  input  logic [6:0]        cmd_col,
  input  logic [15:0]       cmd_symbol,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              err
);

  localparam int WORDS = ROWS * COLS / 2;

  cmd_t        cmd_in;
  cmd_t        head;
  logic        full;
  logic        empty;
  logic        accept;
  logic        out_of_range;
  logic        drop;
  logic        push;
  logic        pop;
  logic [12:0] idx;
  state_e      state;

  assign cmd_in.op     = op_e'(cmd_op);
  assign cmd_in.row    = cmd_row;
  assign cmd_in.col    = cmd_col;
  assign cmd_in.symbol = symbol_t'(cmd_symbol);

  assign cmd_ready    = !full;
  assign accept       = cmd_valid && !full;
  assign out_of_range = (int'(cmd_row) >= ROWS) || (int'(cmd_col) >= COLS);

  // Bad commands are still accepted so upstream never stalls on them.
`ifdef VRAM_NOTE_WRITER_CLEAR_EN
  assign drop = !cmd_op && out_of_range;
`else
  assign drop = cmd_op || out_of_range;
`endif

  assign push = accept && !drop;
  assign pop  = (state == ST_IDLE) && !empty;
  assign idx  = cell_index(head.row, head.col, COLS);
  assign busy = !empty || (state != ST_IDLE);

  note_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      err            <= 1'b0;
    end else begin
      err <= accept && drop;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            avm_write <= 1'b1;
`ifdef VRAM_NOTE_WRITER_CLEAR_EN
            if (head.op == OP_CLEAR) begin
              avm_address    <= '0;
              avm_writedata  <= {head.symbol, head.symbol};
              avm_byteenable <= 4'b1111;
              state          <= ST_CLEAR;
            end else
`endif
            begin
              avm_address    <= ADDR_W'(idx[12:1]);
              avm_writedata  <= idx[0] ? {head.symbol, 16'h0000} : {16'h0000, head.symbol};
              avm_byteenable <= idx[0] ? 4'b1100 : 4'b0011;
              state          <= ST_PUT;
            end
          end
        end
        ST_PUT: begin
          // Dropping write here guarantees an idle cycle between PUTs.
          if (!avm_waitrequest) begin
            avm_write <= 1'b0;
            state     <= ST_IDLE;
          end
        end
`ifdef VRAM_NOTE_WRITER_CLEAR_EN
        ST_CLEAR: begin
          if (!avm_waitrequest) begin
            if (avm_address == ADDR_W'(WORDS - 1)) begin
              avm_write <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              avm_address <= avm_address + ADDR_W'(1);
            end
          end
        end
`endif
        default: begin
          avm_write <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_note_writer.sv
// Scoreboard bench for vram_note_writer: stimulus pushes expected Avalon
// writes into a queue, a negedge monitor pops and compares on each completion.
module tb_vram_note_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [5:0]  cmd_row;
  logic [6:0]  cmd_col;
  logic [15:0] cmd_symbol;
  logic [11:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  vram_note_writer dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_row         (cmd_row),
    .cmd_col         (cmd_col),
    .cmd_symbol      (cmd_symbol),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .err             (err)
  );

  typedef struct {
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors    = 0;
  int  miscompares = 0;
  int  exp_err    = 0;
  int  err_seen   = 0;
  bit  rand_wr    = 1'b0;
  bit  ok;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic fail_evt(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got no/unexpected event expected normal completion", name);
  endtask

  // Reference model: what the VRAM should see for one accepted command.
  task automatic model_cmd(input bit op, input int row, input int col, input logic [15:0] sym);
    wr_t w;
    int  idx;
    if (op) begin
`ifdef VRAM_NOTE_WRITER_CLEAR_EN
      for (int i = 0; i < 2400; i++) begin
        w.a = 12'(i); w.be = 4'hF; w.d = {sym, sym};
        exp_q.push_back(w);
      end
`else
      exp_err++;
`endif
    end else if (row >= 60 || col >= 80) begin
      exp_err++;
    end else begin
      idx = row * 80 + col;
      w.a = 12'(idx / 2);
      if (idx % 2 == 0) begin w.be = 4'b0011; w.d = {16'h0000, sym}; end
      else              begin w.be = 4'b1100; w.d = {sym, 16'h0000}; end
      exp_q.push_back(w);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    if (rand_wr) avm_waitrequest = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send(input bit op, input int row, input int col, input logic [15:0] sym);
    bit acc;
    acc = 1'b0;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_row    = 6'(row);
    cmd_col    = 7'(col);
    cmd_symbol = sym;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = cmd_ready;
      step();
      if (acc) break;
    end
    cmd_valid = 1'b0;
    if (acc) model_cmd(op, row, col, sym);
    else     fail_evt("send_timeout");
  endtask

  task automatic drain(input int limit);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < limit) begin
      step();
      t++;
    end
    if (t >= limit) fail_evt("drain_timeout");
  endtask

  // Monitor: completions, hold-stability under waitrequest, err pulses.
  logic [11:0] p_a;
  logic [3:0]  p_be;
  logic [31:0] p_d;
  bit          p_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_write", 32'(avm_write), 32'd1);
        chk("hold_addr",  32'(avm_address), 32'(p_a));
        chk("hold_be",    32'(avm_byteenable), 32'(p_be));
        chk("hold_data",  avm_writedata, p_d);
      end
      if (avm_write && !avm_waitrequest) begin
        if (exp_q.size() == 0) begin
          fail_evt("unexpected_write");
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(avm_address), 32'(mon_e.a));
          chk("wr_be",   32'(avm_byteenable), 32'(mon_e.be));
          chk("wr_data", avm_writedata, mon_e.d);
        end
      end
      if (err) err_seen++;
      p_stall = avm_write && avm_waitrequest;
      p_a     = avm_address;
      p_be    = avm_byteenable;
      p_d     = avm_writedata;
    end
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_row = '0; cmd_col = '0;
    cmd_symbol = '0; avm_waitrequest = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_addr",  32'(avm_address), 32'd0);
    chk("rst_data",  avm_writedata, 32'd0);
    chk("rst_be",    32'(avm_byteenable), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    #3;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    step();

    // First PUT: latency 2 cycles, single-cycle write
    send(1'b0, 0, 0, 16'hA8D1);
    chk("lat_write_c1", 32'(avm_write), 32'd0);
    chk("lat_busy_c1",  32'(busy), 32'd1);
    step();
    chk("lat_write_c2", 32'(avm_write), 32'd1);
    chk("lat_addr",     32'(avm_address), 32'd0);
    step();
    chk("lat_write_c3", 32'(avm_write), 32'd0);
    chk("lat_busy_c3",  32'(busy), 32'd0);

    // Odd cell
    send(1'b0, 1, 3, 16'h4042);
    drain(50);

    // Stalled PUT
    avm_waitrequest = 1'b1;
    send(1'b0, 7, 11, 16'h2019);
    step();
    chk("stall_write_on", 32'(avm_write), 32'd1);
    repeat (3) step();
    chk("stall_write_held", 32'(avm_write), 32'd1);
    avm_waitrequest = 1'b0;
    step();
    chk("stall_write_off", 32'(avm_write), 32'd0);
    chk("stall_busy_off",  32'(busy), 32'd0);

    // Out-of-range PUTs
    send(1'b0, 60, 0, 16'h1111);
    chk("err_row", 32'(err), 32'd1);
    step();
    chk("err_row_pulse", 32'(err), 32'd0);
    send(1'b0, 0, 80, 16'h2222);
    chk("err_col", 32'(err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_nowrite", 32'(avm_write), 32'd0);
      step();
    end

    // Backpressure: 1 in flight + 4 queued, then a sixth waits
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) send(1'b0, i, 2 * i + 1, 16'(16'h0801 * (i + 1)));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    avm_waitrequest = 1'b0;
    send(1'b0, 59, 79, 16'hF8DB);
    drain(100);

    // Randomized traffic with random waitrequest
    rand_wr = 1'b1;
    for (int n = 0; n < 80; n++) begin
      repeat ($urandom_range(0, 2)) step();
      send(1'b0, $urandom_range(0, 63), $urandom_range(0, 127), 16'($urandom) & 16'hF8DB);
    end
    drain(2000);
    rand_wr = 1'b0;
    avm_waitrequest = 1'b0;

    // CLEAR with a PUT queued behind it
    send(1'b1, 0, 0, 16'h0000);
    send(1'b0, 2, 5, 16'h1234);
    drain(6000);
    send(1'b1, 33, 44, 16'hA8D1);
    drain(6000);
    chk("clear_busy_end", 32'(busy), 32'd0);

    // Reset in the middle of a stalled write
    avm_waitrequest = 1'b1;
    send(1'b0, 5, 5, 16'h5555);
    step();
    chk("midrst_write_on", 32'(avm_write), 32'd1);
    #1 rst = 1'b1;
    #1 chk("midrst_write_off", 32'(avm_write), 32'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (2) step();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_idle", 32'(avm_write), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("err_count", 32'(err_seen), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
